// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// default command/marker values used by the loader and its word assembler.
// No logic; types and constants only.
package imem_loader_pkg;

    localparam int          NB_BITS_DFLT   = 32;
    localparam logic [7:0]  START_CMD_DFLT = 8'h4C;
    localparam logic [31:0] HALT_WORD_DFLT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Purpose: packs a byte stream MSB-first into NB_BITS-wide words.
// Latency: word_vld/word_dat are combinational on the strobe of the last byte.
// Backpressure: none; every byte_vld strobe is consumed in the cycle it arrives.
module imem_word_assembler #(
    parameter int NB_BITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               byte_vld,
    input  logic [7:0]         byte_dat,
    output logic               word_vld,
    output logic [NB_BITS-1:0] word_dat
);

    localparam int NB_BYTES = NB_BITS / 8;
    localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    logic [NB_CNT-1:0]  byte_cnt;
    logic [NB_BITS-1:0] shift_q;

    // The word is visible on the same cycle its last byte arrives, so the
    // loader can register it without an extra pipeline stage.
    assign word_dat = {shift_q[NB_BITS-9:0], byte_dat};
    assign word_vld = byte_vld && (byte_cnt == NB_CNT'(NB_BYTES - 1));

    // Shift register and byte counter; counter wraps after the last byte.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (byte_vld) begin
            shift_q  <= word_dat;
            byte_cnt <= word_vld ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Purpose: loads instruction memory from a UART byte stream; holds the CPU in reset while loading.
// Latency: o_imem_we pulses the cycle after the strobe of each word's last byte.
// Backpressure: none; bytes in LOAD and WRITE are always accepted (optional IMEM_LOADER_CHECKSUM_EN).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                 NB_BITS    = NB_BITS_DFLT,
    parameter int                 FILE_DEPTH = 60,
    parameter int                 NB_ADDR    = 6,
    parameter logic [7:0]         START_CMD  = START_CMD_DFLT,
    parameter logic [NB_BITS-1:0] HALT_WORD  = NB_BITS'(HALT_WORD_DFLT)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_BITS-1:0] o_imem_data,
    output logic               o_imem_we,
    output logic               o_pc_we,
    output logic               o_if_id_we,
    output logic               o_cpu_rst,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_BITS-1:0] o_checksum
);

    state_t               state_q;
    state_t               state_d;
    logic [NB_ADDR-1:0]   addr_cnt;
    logic                 byte_vld;
    logic                 start_acc;
    logic                 last_wr;
    logic                 word_vld;
    logic [NB_BITS-1:0]   word_dat;
    logic                 busy_d;
    logic                 run_d;

    // A byte during the single WRITE cycle belongs to the next word.
    assign byte_vld  = i_rx_valid && ((state_q == ST_LOAD) || (state_q == ST_WRITE));
    assign start_acc = i_rx_valid && (i_rx_data == START_CMD) &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // In WRITE, o_imem_data holds the word being written at addr_cnt.
    assign last_wr   = (o_imem_data == HALT_WORD) ||
                       (addr_cnt == NB_ADDR'(FILE_DEPTH - 1));

    imem_word_assembler #(
        .NB_BITS (NB_BITS)
    ) u_asm (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (start_acc),
        .byte_vld (byte_vld),
        .byte_dat (i_rx_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, plus next values of the registered status outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_LOAD;
            ST_LOAD:  if (word_vld)  state_d = ST_WRITE;
            ST_WRITE: state_d = last_wr ? ST_DONE : ST_LOAD;
            ST_DONE:  if (start_acc) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_WRITE);
        run_d  = (state_d == ST_DONE);
    end

    // Word address: restarts at 0 on each load, never advances past the last word.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_acc)                   addr_cnt <= '0;
        else if (state_q == ST_WRITE && !last_wr) addr_cnt <= addr_cnt + 1'b1;
    end

    // Registered memory-write port and pipeline-control outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_cpu_rst   <= 1'b1;
            o_pc_we     <= 1'b0;
            o_if_id_we  <= 1'b0;
        end else begin
            o_imem_we <= word_vld;
            if (word_vld) begin
                o_imem_addr <= addr_cnt;
                o_imem_data <= word_dat;
            end
            o_busy     <= busy_d;
            o_done     <= run_d;
            o_cpu_rst  <= !run_d;
            o_pc_we    <= run_d;
            o_if_id_we <= run_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [NB_BITS-1:0] csum_q;

    // XOR of all words written since the last START_CMD; frozen in DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_acc)      csum_q <= '0;
        else if (state_q == ST_WRITE) csum_q <= csum_q ^ o_imem_data;
    end

    assign o_checksum = csum_q;
`else
    assign o_checksum = '0;
`endif

endmodule
